srio_xfer_scheduler: RTL and testbench
======================================

# srio_xfer_scheduler

Autonomous transfer sequencer between the host-programmed SRIO configuration registers and the SRIO initiator core. It watches the outgoing data FIFO level and chops each frame into bursts of at most BURST_BYTES. For each burst it loads the initiator's ucfg_* descriptor and triggers it. After the last burst of a frame it sends a doorbell and waits for the response. Destination buffers ping-pong between two regions so the far end can consume one while the other fills.

## Interface
Parameters:
- BURST_BYTES, 256, max bytes per NWRITE burst; multiple of 8, ≤256
- DB_TIMEOUT, 65535, cycles to wait for srio_db_resp before declaring a doorbell timeout
- BUSY_GUARD, 16, cycles to wait for srio_initial_busy to rise after a trigger

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- cfg_enable  in  1  scheduler run enable (level)
- cfg_dest_id  in  8  target device ID
- cfg_dest_base  in  34  buffer-0 destination address
- cfg_buf_stride  in  34  offset from buffer 0 to buffer 1
- cfg_frame_bytes  in  24  frame length in bytes; multiple of 8, nonzero
- fifo_rd_len  in  10  64-bit words available in the data FIFO
- srio_initial_busy  in  1  initiator transaction in progress
- srio_db_resp  in  1  one-cycle doorbell response strobe
- ucfg_dest_id  out  8  descriptor target ID
- ucfg_src_start_addr  out  32  FIFO-relative source byte offset within the frame
- ucfg_dest_start_addr  out  34  descriptor destination address
- ucfg_byte_count  out  9  burst byte count (1..256)
- ucfg_db_info  out  16  doorbell payload
- ucfg_wr_n  out  1  active-low descriptor load strobe
- ucfg_normal_trigger  out  1  one-cycle NWRITE start
- ucfg_db_trigger  out  1  one-cycle doorbell start
- sched_busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  completed frames, wraps
- error_conter  out  32  doorbell timeouts plus busy-guard misses; saturates at all-ones

## Operation
- Reset values: all ucfg_* buses 0, ucfg_wr_n=1, both triggers 0, sched_busy 0, frame_cnt 0, error_conter 0, buffer select 0, FSM in IDLE.
- IDLE: when cfg_enable=1, latch cfg_* into frame registers, set remaining = cfg_frame_bytes and offset = 0, then go to WAIT_DATA.
- WAIT_DATA: burst = min(BURST_BYTES, remaining). Advance to LOAD when fifo_rd_len×8 ≥ burst, using a 13-bit compare with no truncation.
- LOAD: ucfg_wr_n=0 for one cycle. Descriptor fields:
  - dest_start_addr = base + (buf_sel ? stride : 0) + offset, modulo 2^34
  - src_start_addr = offset
  - byte_count = burst
- TRIG: ucfg_normal_trigger=1 for one cycle.
- WAIT_BUSY: wait for srio_initial_busy=1. If it has not risen after BUSY_GUARD cycles, increment error_conter and treat the burst as done.
- WAIT_DONE: wait for srio_initial_busy=0. Then offset += burst and remaining −= burst.
  - remaining ≠ 0 → WAIT_DATA.
  - remaining = 0 → DB_LOAD.
- DB_LOAD: ucfg_db_info = {buf_sel, frame_cnt[14:0]}; ucfg_wr_n=0 for one cycle.
- DB_TRIG: ucfg_db_trigger=1 for one cycle.
- DB_WAIT: a srio_db_resp pulse, or DB_TIMEOUT cycles elapsing, ends the wait. On timeout, increment error_conter. A response arriving in the same cycle as the timeout counts as a response.
- End of DB_WAIT: frame_cnt++, buf_sel toggles. Go to WAIT_DATA with a fresh frame latch if cfg_enable=1, otherwise to IDLE.
- cfg_enable low mid-frame: the current burst completes (through WAIT_DONE), then the FSM returns to IDLE. No doorbell is sent, frame_cnt is unchanged, and buf_sel is kept.
- cfg_* changes take effect only at frame start.
- srio_db_resp outside DB_WAIT is ignored.

## Timing
- Latency from WAIT_DATA condition true to ucfg_wr_n low: 1 cycle.
- ucfg_wr_n low to normal_trigger: 1 cycle. The descriptor is stable from LOAD until the next LOAD.
- Minimum gap between triggers is 4 cycles, even with busy pulsing for only 1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- Asynchronous reset mid-transfer returns every output to its reset value immediately.

## Structure
- Package srio_sched_pkg holds:
  - FSM state encoding: IDLE, WAIT_DATA, LOAD, TRIG, WAIT_BUSY, WAIT_DONE, DB_LOAD, DB_TRIG, DB_WAIT
  - default constants for BURST_BYTES, DB_TIMEOUT and BUSY_GUARD
- One sub-module, srio_sched_timer: a loadable down-counter with an expire flag, shared by the busy guard and the doorbell timeout.

## Test plan
- frame 80 bytes, FIFO full, busy high 3 cycles per burst → one burst with byte_count=80, dest=base, then a doorbell with info 0x8000? no: info 0x0000; after the response frame_cnt=1.
- frame 600 bytes, base 0x1000, BURST_BYTES=256 → bursts of 256/256/88 at 0x1000/0x1100/0x1200, src offsets 0/256/512, then a single doorbell.
- Two consecutive frames of 64 bytes, stride 0x10000 → second frame's dest = base+0x10000 and db_info=0x8001.
- fifo_rd_len held at 10 with 128-byte frame → no trigger while 10×8 < 128; trigger within 2 cycles of fifo_rd_len reaching 16.
- srio_db_resp never asserted → after DB_TIMEOUT cycles, error_conter=1, frame_cnt increments, next frame starts.
- cfg_enable dropped during the 2nd burst of a 600-byte frame → that burst completes, no doorbell, IDLE with sched_busy=0; async reset in WAIT_DONE → all outputs return to reset values.

Source files
------------

// File: rtl/srio_sched_pkg.sv
// Shared definitions for the SRIO transfer scheduler: FSM encoding and default tuning constants.
package srio_sched_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_DATA = 4'd1,
    LOAD      = 4'd2,
    TRIG      = 4'd3,
    WAIT_BUSY = 4'd4,
    WAIT_DONE = 4'd5,
    DB_LOAD   = 4'd6,
    DB_TRIG   = 4'd7,
    DB_WAIT   = 4'd8
  } sched_state_t;

  localparam int DEF_BURST_BYTES = 256;
  localparam int DEF_DB_TIMEOUT  = 65535;
  localparam int DEF_BUSY_GUARD  = 16;
  localparam int TIMER_W         = 16;

endpackage

// File: rtl/srio_sched_timer.sv
// Loadable down-counter; expired is high once the count has run down to zero.
module srio_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/srio_xfer_scheduler.sv
// Chops each frame into bursts for the SRIO initiator, then rings a doorbell and
// alternates the destination buffer per frame.
module srio_xfer_scheduler
  import srio_sched_pkg::*;
#(
  parameter int BURST_BYTES = DEF_BURST_BYTES,
  parameter int DB_TIMEOUT  = DEF_DB_TIMEOUT,
  parameter int BUSY_GUARD  = DEF_BUSY_GUARD
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_enable,
  input  logic [7:0]  cfg_dest_id,
  input  logic [33:0] cfg_dest_base,
  input  logic [33:0] cfg_buf_stride,
  input  logic [23:0] cfg_frame_bytes,
  input  logic [9:0]  fifo_rd_len,
  input  logic        srio_initial_busy,
  input  logic        srio_db_resp,
  output logic [7:0]  ucfg_dest_id,
  output logic [31:0] ucfg_src_start_addr,
  output logic [33:0] ucfg_dest_start_addr,
  output logic [8:0]  ucfg_byte_count,
  output logic [15:0] ucfg_db_info,
  output logic        ucfg_wr_n,
  output logic        ucfg_normal_trigger,
  output logic        ucfg_db_trigger,
  output logic        sched_busy,
  output logic [15:0] frame_cnt,
  output logic [31:0] error_conter,
  output logic [3:0]  dbg_state
);

  // Handshake: ucfg_wr_n low for one cycle loads the descriptor; the trigger
  // follows one cycle later. The initiator acknowledges by raising busy and
  // signals completion by dropping it; doorbells complete on a db_resp strobe.

  sched_state_t         state;
  logic [7:0]           dest_id_q;
  logic [33:0]          base_q;
  logic [33:0]          stride_q;
  logic [23:0]          remaining;
  logic [23:0]          offset;
  logic                 buf_sel;

  logic [8:0]           burst;
  logic                 data_ok;
  logic [33:0]          dest_calc;
  logic                 guard_miss;
  logic                 burst_end;
  logic                 db_done;
  logic                 db_timeout;
  logic                 frame_start;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_val;
  logic                 timer_expired;

  always_comb begin
    burst       = (remaining > 24'(BURST_BYTES)) ? 9'(BURST_BYTES) : remaining[8:0];
    data_ok     = {fifo_rd_len, 3'b000} >= {4'b0000, burst};
    dest_calc   = base_q + (buf_sel ? stride_q : 34'd0) + {10'd0, offset};
    guard_miss  = (state == WAIT_BUSY) && !srio_initial_busy && timer_expired;
    burst_end   = guard_miss || ((state == WAIT_DONE) && !srio_initial_busy);
    db_done     = (state == DB_WAIT) && (srio_db_resp || timer_expired);
    db_timeout  = (state == DB_WAIT) && !srio_db_resp && timer_expired;
    frame_start = cfg_enable && ((state == IDLE) || db_done);
    timer_load  = (state == TRIG) || (state == DB_TRIG);
    timer_val   = (state == TRIG) ? TIMER_W'(BUSY_GUARD) : TIMER_W'(DB_TIMEOUT);
  end

  srio_sched_timer #(.W(TIMER_W)) u_timer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state                <= IDLE;
      dest_id_q            <= '0;
      base_q               <= '0;
      stride_q             <= '0;
      remaining            <= '0;
      offset               <= '0;
      buf_sel              <= 1'b0;
      ucfg_dest_id         <= '0;
      ucfg_src_start_addr  <= '0;
      ucfg_dest_start_addr <= '0;
      ucfg_byte_count      <= '0;
      ucfg_db_info         <= '0;
      ucfg_wr_n            <= 1'b1;
      ucfg_normal_trigger  <= 1'b0;
      ucfg_db_trigger      <= 1'b0;
      sched_busy           <= 1'b0;
      frame_cnt            <= '0;
      error_conter         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            state      <= WAIT_DATA;
            sched_busy <= 1'b1;
          end
        end
        WAIT_DATA: begin
          if (!cfg_enable) begin
            state      <= IDLE;
            sched_busy <= 1'b0;
          end else if (data_ok) begin
            state                <= LOAD;
            ucfg_wr_n            <= 1'b0;
            ucfg_dest_id         <= dest_id_q;
            ucfg_src_start_addr  <= {8'd0, offset};
            ucfg_dest_start_addr <= dest_calc;
            ucfg_byte_count      <= burst;
          end
        end
        LOAD: begin
          state               <= TRIG;
          ucfg_wr_n           <= 1'b1;
          ucfg_normal_trigger <= 1'b1;
        end
        TRIG: begin
          state               <= WAIT_BUSY;
          ucfg_normal_trigger <= 1'b0;
        end
        WAIT_BUSY: begin
          if (srio_initial_busy) state <= WAIT_DONE;
        end
        DB_LOAD: begin
          state           <= DB_TRIG;
          ucfg_wr_n       <= 1'b1;
          ucfg_db_trigger <= 1'b1;
        end
        DB_TRIG: begin
          state           <= DB_WAIT;
          ucfg_db_trigger <= 1'b0;
        end
        DB_WAIT: begin
          if (db_done) begin
            frame_cnt  <= frame_cnt + 16'd1;
            buf_sel    <= ~buf_sel;
            state      <= cfg_enable ? WAIT_DATA : IDLE;
            sched_busy <= cfg_enable;
          end
        end
        default: ;
      endcase

      // A missed busy guard is treated exactly like a completed burst.
      if (burst_end) begin
        offset    <= offset + {15'd0, ucfg_byte_count};
        remaining <= remaining - {15'd0, ucfg_byte_count};
        if (!cfg_enable) begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end else if (remaining == {15'd0, ucfg_byte_count}) begin
          state        <= DB_LOAD;
          ucfg_wr_n    <= 1'b0;
          ucfg_db_info <= {buf_sel, frame_cnt[14:0]};
        end else begin
          state <= WAIT_DATA;
        end
      end

      if ((guard_miss || db_timeout) && (error_conter != '1)) begin
        error_conter <= error_conter + 32'd1;
      end

      if (frame_start) begin
        dest_id_q <= cfg_dest_id;
        base_q    <= cfg_dest_base;
        stride_q  <= cfg_buf_stride;
        remaining <= cfg_frame_bytes;
        offset    <= '0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_srio_xfer_scheduler.sv
// Scoreboarded bench for srio_xfer_scheduler with a small initiator/doorbell responder model.
module tb_srio_xfer_scheduler;

  localparam int EW = 91;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cfg_enable;
  logic [7:0]  cfg_dest_id;
  logic [33:0] cfg_dest_base;
  logic [33:0] cfg_buf_stride;
  logic [23:0] cfg_frame_bytes;
  logic [9:0]  fifo_rd_len;
  logic        srio_initial_busy;
  logic        srio_db_resp;
  logic [7:0]  ucfg_dest_id;
  logic [31:0] ucfg_src_start_addr;
  logic [33:0] ucfg_dest_start_addr;
  logic [8:0]  ucfg_byte_count;
  logic [15:0] ucfg_db_info;
  logic        ucfg_wr_n;
  logic        ucfg_normal_trigger;
  logic        ucfg_db_trigger;
  logic        sched_busy;
  logic [15:0] frame_cnt;
  logic [31:0] error_conter;
  logic [3:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int db_cnt = 0;
  int busy_len = 3;
  bit db_resp_en = 1'b1;

  srio_xfer_scheduler #(.BURST_BYTES(256), .DB_TIMEOUT(40), .BUSY_GUARD(8)) dut (
    .sys_clk              (sys_clk),
    .sys_rst_n            (sys_rst_n),
    .cfg_enable           (cfg_enable),
    .cfg_dest_id          (cfg_dest_id),
    .cfg_dest_base        (cfg_dest_base),
    .cfg_buf_stride       (cfg_buf_stride),
    .cfg_frame_bytes      (cfg_frame_bytes),
    .fifo_rd_len          (fifo_rd_len),
    .srio_initial_busy    (srio_initial_busy),
    .srio_db_resp         (srio_db_resp),
    .ucfg_dest_id         (ucfg_dest_id),
    .ucfg_src_start_addr  (ucfg_src_start_addr),
    .ucfg_dest_start_addr (ucfg_dest_start_addr),
    .ucfg_byte_count      (ucfg_byte_count),
    .ucfg_db_info         (ucfg_db_info),
    .ucfg_wr_n            (ucfg_wr_n),
    .ucfg_normal_trigger  (ucfg_normal_trigger),
    .ucfg_db_trigger      (ucfg_db_trigger),
    .sched_busy           (sched_busy),
    .frame_cnt            (frame_cnt),
    .error_conter         (error_conter),
    .dbg_state            (dbg_state)
  );

  // Clock and reset
  always #5 sys_clk = ~sys_clk;

  function automatic logic [EW-1:0] ev(input logic kind, input logic [7:0] id,
                                        input logic [31:0] src, input logic [33:0] dst,
                                        input logic [15:0] val);
    return {kind, id, src, dst, val};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event 0x%0h, expected queue empty", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
    end
  endtask

  // Scoreboard monitor: every trigger pops one expected descriptor or doorbell
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (ucfg_normal_trigger) begin
        trig_cnt++;
        sb_compare("burst_desc", ev(1'b0, ucfg_dest_id, ucfg_src_start_addr,
                                    ucfg_dest_start_addr, {7'd0, ucfg_byte_count}));
      end
      if (ucfg_db_trigger) begin
        db_cnt++;
        sb_compare("doorbell", ev(1'b1, 8'd0, 32'd0, 34'd0, ucfg_db_info));
      end
    end
  end

  // Initiator model: busy rises the cycle after a trigger and holds busy_len cycles
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && ucfg_normal_trigger && busy_len > 0) begin
        @(posedge sys_clk); #1 srio_initial_busy = 1'b1;
        repeat (busy_len) @(posedge sys_clk);
        #1 srio_initial_busy = 1'b0;
      end
    end
  end

  // Doorbell responder: one-cycle response strobe one cycle after the trigger
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && ucfg_db_trigger && db_resp_en) begin
        @(posedge sys_clk); #1 srio_db_resp = 1'b1;
        @(posedge sys_clk); #1 srio_db_resp = 1'b0;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_dest_id"}, ucfg_dest_id, 0);
    check({tag, "_src"}, ucfg_src_start_addr, 0);
    check({tag, "_dest"}, ucfg_dest_start_addr, 0);
    check({tag, "_count"}, ucfg_byte_count, 0);
    check({tag, "_db_info"}, ucfg_db_info, 0);
    check({tag, "_wr_n"}, ucfg_wr_n, 1);
    check({tag, "_ntrig"}, ucfg_normal_trigger, 0);
    check({tag, "_dbtrig"}, ucfg_db_trigger, 0);
    check({tag, "_busy"}, sched_busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_err"}, error_conter, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    cfg_enable = 1'b0;
    srio_initial_busy = 1'b0;
    srio_db_resp = 1'b0;
    fifo_rd_len = 10'd1023;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
  endtask

  task automatic set_cfg(input logic [7:0] id, input logic [33:0] base,
                         input logic [33:0] stride, input logic [23:0] bytes);
    @(posedge sys_clk); #1;
    cfg_dest_id = id;
    cfg_dest_base = base;
    cfg_buf_stride = stride;
    cfg_frame_bytes = bytes;
  endtask

  // Keep enable high until target doorbells have gone out, then wait for IDLE
  task automatic run_frames(input int n, input string name);
    int target;
    target = db_cnt + n;
    @(posedge sys_clk); #1 cfg_enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge sys_clk); #1;
      if (cfg_enable && db_cnt >= target) cfg_enable = 1'b0;
      if (!cfg_enable && !sched_busy) break;
    end
    check({name, "_end_idle"}, {cfg_enable, sched_busy}, 0);
  endtask

  task automatic wait_trig(input int target, input string name);
    for (int i = 0; i < 1000 && trig_cnt < target; i++) @(posedge sys_clk);
    #1 check({name, "_trig_seen"}, trig_cnt, target);
  endtask

  initial begin
    int base_trig;
    sys_rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_dest_id = '0;
    cfg_dest_base = '0;
    cfg_buf_stride = '0;
    cfg_frame_bytes = '0;
    fifo_rd_len = 10'd1023;
    srio_initial_busy = 1'b0;
    srio_db_resp = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 check_reset("por");
    @(negedge sys_clk) sys_rst_n = 1'b1;

    // Single 80-byte frame
    set_cfg(8'h5A, 34'h4000, 34'h10000, 24'd80);
    exp_q.push_back(ev(1'b0, 8'h5A, 32'd0, 34'h4000, 16'd80));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h0000));
    run_frames(1, "t80");
    check("t80_frame_cnt", frame_cnt, 1);
    check("t80_err", error_conter, 0);

    // 600 bytes split into 256/256/88
    do_reset();
    set_cfg(8'h11, 34'h1000, 34'h10000, 24'd600);
    exp_q.push_back(ev(1'b0, 8'h11, 32'd0,   34'h1000, 16'd256));
    exp_q.push_back(ev(1'b0, 8'h11, 32'd256, 34'h1100, 16'd256));
    exp_q.push_back(ev(1'b0, 8'h11, 32'd512, 34'h1200, 16'd88));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h0000));
    run_frames(1, "t600");
    check("t600_frame_cnt", frame_cnt, 1);

    // Two back-to-back frames, second in buffer 1 with address wrap at 2^34
    do_reset();
    set_cfg(8'hC3, 34'h3_FFFF_0000, 34'h10000, 24'd64);
    exp_q.push_back(ev(1'b0, 8'hC3, 32'd0, 34'h3_FFFF_0000, 16'd64));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h0000));
    exp_q.push_back(ev(1'b0, 8'hC3, 32'd0, 34'h0, 16'd64));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h8001));
    run_frames(2, "tpp");
    check("tpp_frame_cnt", frame_cnt, 2);

    // FIFO threshold: 10 and 15 words are short of 128 bytes, 16 is exactly enough
    do_reset();
    set_cfg(8'h22, 34'h5000, 34'h10000, 24'd128);
    exp_q.push_back(ev(1'b0, 8'h22, 32'd0, 34'h5000, 16'd128));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h0000));
    base_trig = trig_cnt;
    @(posedge sys_clk); #1 fifo_rd_len = 10'd10; cfg_enable = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 check("thr_10_no_trig", trig_cnt, base_trig);
    fifo_rd_len = 10'd15;
    repeat (10) @(posedge sys_clk);
    #1 check("thr_15_no_trig", trig_cnt, base_trig);
    @(posedge sys_clk); #1 fifo_rd_len = 10'd16;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); #1 check("thr_16_trig_2cyc", trig_cnt, base_trig + 1);
    run_frames(1, "thr");

    // Doorbell never answered: two timeouts, frames still advance
    do_reset();
    db_resp_en = 1'b0;
    set_cfg(8'h33, 34'h8000, 34'h800, 24'd32);
    exp_q.push_back(ev(1'b0, 8'h33, 32'd0, 34'h8000, 16'd32));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h0000));
    exp_q.push_back(ev(1'b0, 8'h33, 32'd0, 34'h8800, 16'd32));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h8001));
    run_frames(2, "tdb");
    check("tdb_err", error_conter, 2);
    check("tdb_frame_cnt", frame_cnt, 2);
    db_resp_en = 1'b1;

    // Initiator never goes busy: guard miss counts an error, burst treated as done
    do_reset();
    busy_len = 0;
    set_cfg(8'h44, 34'h200, 34'h10000, 24'd16);
    exp_q.push_back(ev(1'b0, 8'h44, 32'd0, 34'h200, 16'd16));
    exp_q.push_back(ev(1'b1, 8'd0, 32'd0, 34'd0, 16'h0000));
    run_frames(1, "tgd");
    check("tgd_err", error_conter, 1);
    check("tgd_frame_cnt", frame_cnt, 1);
    busy_len = 10;

    // Enable dropped during the 2nd burst of a 600-byte frame
    do_reset();
    set_cfg(8'h11, 34'h1000, 34'h10000, 24'd600);
    exp_q.push_back(ev(1'b0, 8'h11, 32'd0,   34'h1000, 16'd256));
    exp_q.push_back(ev(1'b0, 8'h11, 32'd256, 34'h1100, 16'd256));
    base_trig = trig_cnt;
    @(posedge sys_clk); #1 cfg_enable = 1'b1;
    wait_trig(base_trig + 2, "tab");
    @(posedge sys_clk); #1 cfg_enable = 1'b0;
    for (int i = 0; i < 200 && sched_busy; i++) @(posedge sys_clk);
    repeat (20) @(posedge sys_clk);
    #1;
    check("tab_busy", sched_busy, 0);
    check("tab_trigs", trig_cnt, base_trig + 2);
    check("tab_frame_cnt", frame_cnt, 0);
    check("tab_err", error_conter, 0);
    check("tab_state", dbg_state, 0);

    // Restart, then asynchronous reset while the burst is in WAIT_DONE
    base_trig = trig_cnt;
    exp_q.push_back(ev(1'b0, 8'h11, 32'd0, 34'h1000, 16'd256));
    cfg_enable = 1'b1;
    wait_trig(base_trig + 1, "tar");
    for (int i = 0; i < 20 && !srio_initial_busy; i++) @(posedge sys_clk);
    @(posedge sys_clk); #3 sys_rst_n = 1'b0;
    #1 check_reset("async");
    cfg_enable = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (15) @(posedge sys_clk);

    #1 check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
